first_zero_encoder: RTL and testbench
=====================================

Name: first_zero_encoder

Overview:
- 8-input first-zero priority encoder used by the port read dispatcher, the WRR scheduler for 8 priority queues.
- Input is the masked queue-empty vector: bit i = 1 means queue i is empty or masked.
- Reports the lowest-numbered queue whose bit is 0.
- Provides a combinational index, a registered copy, and an "all set / none available" flag.

Parameters:
- N, 8, number of select inputs; fixed at 8 for this block, other values unsupported.
- IDX_W, 4, index width; must encode 0..N, so N=8 needs 4 bits.
- NONE_IDX, 8, index code reported when no bit of select is 0.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  load enable for the registered outputs.
- select  input  8  bit i = 1: queue i empty/masked; bit i = 0: queue i eligible.
- idx  output  4  combinational index of the lowest i with select[i]==0; NONE_IDX if none.
- all_set  output  1  combinational; 1 when select == 8'hFF.
- idx_q  output  4  registered idx.
- all_set_q  output  1  registered all_set.

Behaviour:
- Clocking and reset: one clock domain, clk. Reset is asynchronous and active-high on rst.
- Combinational idx: purely combinational from select, zero latency.
  - idx = min{i : select[i]==0}; bit 0 has highest priority.
  - Examples: select=8'hFE gives idx=0; 8'h0F gives 4; 8'h7F gives 7.
  - select=8'hFF gives idx=8 (NONE_IDX).
- idx is never X for any 2-state select. Values 9..15 are never produced.
- all_set is 1 exactly when idx==8.
- Registered outputs:
  - On rst assertion, idx_q=4'd8 and all_set_q=1 immediately, with no clock required.
  - After rst deasserts, at each rising clk edge with en=1: idx_q<=idx and all_set_q<=all_set.
  - With en=0, the registered outputs hold their value.
  - Latency select->idx_q is 1 cycle.
- Simultaneous rst and en: rst wins.
- Reset mid-operation: registered outputs return to 8/1 asynchronously. Combinational outputs are unaffected by rst.
- Output use: a WRR caller builds mask = bits 0..idx set, i.e. (1<<(idx+1))-1. When idx=8 that expression is 8'hFF; callers treat idx=8 as "clear mask". No state is kept inside this block.
- No internal state other than the output registers (and the optional one-hot register below).

Optional Feature:
- Macro: FIRST_ZERO_ONEHOT_EN.
- When defined, add output port onehot_q [7:0]:
  - Registered one-hot form of idx: bit idx set, all bits zero when idx==8.
  - Loads on the same en edge as idx_q.
  - Reset value 8'h00 (async, active-high rst).
- When not defined, the port does not exist and no extra flops are built.
- Core behaviour is identical in both builds.

Test Plan:
- Reset: assert rst with clk idle -> idx_q=8, all_set_q=1 (onehot_q=8'h00 if enabled) with no clock edge; deassert -> values hold until first en edge.
- Single zero sweep: for i=0..7 drive select=~(8'h01<<i) -> idx=i, all_set=0; after one en=1 edge, idx_q=i.
- Priority: select=8'h00 -> idx=0; 8'hF0 -> 0; 8'h0F -> 4; 8'h5F -> 5; 8'hBF -> 6.
- None available: select=8'hFF -> idx=8, all_set=1; after en edge idx_q=8, all_set_q=1, onehot_q=8'h00.
- Enable hold: latch select=8'h3F (idx_q=6), then drop en and drive 8'hFE -> idx=0 immediately, idx_q stays 6; raise en -> idx_q=0 next edge.
- Exhaustive: all 256 select values against the reference model min-zero-index / 8 -> idx, all_set, and idx_q one cycle later all match; assert rst mid-sweep -> registered outputs go to 8/1 asynchronously.

Source files
------------

// File: rtl/first_zero_encoder.sv
// Lowest-zero priority encoder for the WRR dispatcher; optional registered one-hot under FIRST_ZERO_ONEHOT_EN.
// Latency: idx/all_set combinational, idx_q/all_set_q one cycle after an en edge.
// Backpressure: none; en=0 holds the registered outputs.
module first_zero_encoder #(
    parameter int N        = 8,
    parameter int IDX_W    = 4,
    parameter int NONE_IDX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N-1:0]     select,
    output logic [IDX_W-1:0] idx,
    output logic             all_set,
    output logic [IDX_W-1:0] idx_q,
    output logic             all_set_q
`ifdef FIRST_ZERO_ONEHOT_EN
    ,
    output logic [N-1:0]     onehot_q
`endif
);

    logic [IDX_W-1:0] w_idx;
    logic             w_all_set;

    // Scan from the top down so the lowest eligible queue is the last to write.
    always_comb begin
        w_idx = IDX_W'(NONE_IDX);
        for (int i = N - 1; i >= 0; i--) begin
            if (!select[i]) begin
                w_idx = IDX_W'(i);
            end
        end
    end

    assign w_all_set = &select;
    assign idx       = w_idx;
    assign all_set   = w_all_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q     <= IDX_W'(NONE_IDX);
            all_set_q <= 1'b1;
        end else if (en) begin
            idx_q     <= w_idx;
            all_set_q <= w_all_set;
        end
    end

`ifdef FIRST_ZERO_ONEHOT_EN
    logic [N-1:0] w_onehot;

    // Isolates the lowest zero of select; an all-ones select carries out to zero.
    assign w_onehot = ~select & (select + N'(1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            onehot_q <= '0;
        end else if (en) begin
            onehot_q <= w_onehot;
        end
    end
`endif

endmodule

// File: tb/tb_first_zero_encoder.sv
// Bench for first_zero_encoder: vector table, hand sequences, exhaustive sweep with scoreboard.
module tb_first_zero_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] select;
    logic [3:0] idx;
    logic       all_set;
    logic [3:0] idx_q;
    logic       all_set_q;
`ifdef FIRST_ZERO_ONEHOT_EN
    logic [7:0] onehot_q;
`endif

    first_zero_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .select    (select),
        .idx       (idx),
        .all_set   (all_set),
        .idx_q     (idx_q),
        .all_set_q (all_set_q)
`ifdef FIRST_ZERO_ONEHOT_EN
        ,
        .onehot_q  (onehot_q)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] sel;
        logic [3:0] exp_idx;
        logic       exp_all;
    } vec_t;

    typedef struct packed {
        logic [3:0] exp_idx;
        logic       exp_all;
        logic [7:0] exp_oh;
    } sb_t;

    int  checks = 0;
    int  errors = 0;
    sb_t sb_q[$];

    function automatic logic [3:0] ref_idx(input logic [7:0] s);
        for (int i = 0; i < 8; i++) begin
            if (s[i] == 1'b0) return 4'(i);
        end
        return 4'd8;
    endfunction

    function automatic logic [7:0] ref_oh(input logic [7:0] s);
        logic [3:0] k;
        k = ref_idx(s);
        return (k == 4'd8) ? 8'h00 : (8'h01 << k);
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, check combinational outputs, queue the registered expectation.
    task automatic drive(input logic [7:0] s, input logic e, input logic [3:0] ei, input logic ea);
        sb_t item;
        @(negedge clk);
        select = s;
        en     = e;
        #1;
        check("idx", {4'd0, idx}, {4'd0, ei});
        check("all_set", {7'd0, all_set}, {7'd0, ea});
        if (e) begin
            item.exp_idx = ei;
            item.exp_all = ea;
            item.exp_oh  = ref_oh(s);
            sb_q.push_back(item);
        end
    endtask

    task automatic clock_and_check();
        sb_t item;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got empty queue expected an entry");
        end else begin
            item = sb_q.pop_front();
            check("idx_q", {4'd0, idx_q}, {4'd0, item.exp_idx});
            check("all_set_q", {7'd0, all_set_q}, {7'd0, item.exp_all});
`ifdef FIRST_ZERO_ONEHOT_EN
            check("onehot_q", onehot_q, item.exp_oh);
`endif
        end
    endtask

    initial begin
        vec_t vecs[$];
        logic [7:0] s;

        for (int i = 0; i < 8; i++) begin
            s = ~(8'h01 << i);
            vecs.push_back('{sel: s, exp_idx: 4'(i), exp_all: 1'b0});
        end
        vecs.push_back('{sel: 8'h00, exp_idx: 4'd0, exp_all: 1'b0});
        vecs.push_back('{sel: 8'hF0, exp_idx: 4'd0, exp_all: 1'b0});
        vecs.push_back('{sel: 8'h0F, exp_idx: 4'd4, exp_all: 1'b0});
        vecs.push_back('{sel: 8'h5F, exp_idx: 4'd5, exp_all: 1'b0});
        vecs.push_back('{sel: 8'hBF, exp_idx: 4'd6, exp_all: 1'b0});
        vecs.push_back('{sel: 8'h7F, exp_idx: 4'd7, exp_all: 1'b0});
        vecs.push_back('{sel: 8'hFF, exp_idx: 4'd8, exp_all: 1'b1});

        // Reset while the clock is low and before any rising edge.
        rst    = 1'b0;
        en     = 1'b0;
        select = 8'hFF;
        #2 rst = 1'b1;
        #1;
        check("reset idx_q", {4'd0, idx_q}, 8'd8);
        check("reset all_set_q", {7'd0, all_set_q}, 8'd1);
`ifdef FIRST_ZERO_ONEHOT_EN
        check("reset onehot_q", onehot_q, 8'h00);
`endif
        rst    = 1'b0;
        select = 8'h00;
        @(posedge clk);
        #1;
        check("hold after reset idx_q", {4'd0, idx_q}, 8'd8);
        check("hold after reset all_set_q", {7'd0, all_set_q}, 8'd1);

        foreach (vecs[k]) begin
            drive(vecs[k].sel, 1'b1, vecs[k].exp_idx, vecs[k].exp_all);
            clock_and_check();
        end

        // Enable hold sequence.
        drive(8'h3F, 1'b1, 4'd6, 1'b0);
        clock_and_check();
        drive(8'hFE, 1'b0, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        check("en hold idx_q", {4'd0, idx_q}, 8'd6);
        check("en hold all_set_q", {7'd0, all_set_q}, 8'd0);
        drive(8'hFE, 1'b1, 4'd0, 1'b0);
        clock_and_check();

        // Reset wins over a simultaneous enable edge.
        drive(8'h0F, 1'b1, 4'd4, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        void'(sb_q.pop_front());
        check("rst over en idx_q", {4'd0, idx_q}, 8'd8);
        check("rst over en all_set_q", {7'd0, all_set_q}, 8'd1);
        check("rst leaves idx", {4'd0, idx}, 8'd4);
        rst = 1'b0;

        for (int v = 0; v < 256; v++) begin
            s = 8'(v);
            drive(s, 1'b1, ref_idx(s), (s == 8'hFF));
            clock_and_check();
            if (v == 128) begin
                #2 rst = 1'b1;
                #1;
                check("mid-sweep reset idx_q", {4'd0, idx_q}, 8'd8);
                check("mid-sweep reset all_set_q", {7'd0, all_set_q}, 8'd1);
                check("mid-sweep comb idx", {4'd0, idx}, {4'd0, ref_idx(s)});
                rst = 1'b0;
            end
        end

        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard drain: got %0d entries expected 0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
